cbb_rr_arb: RTL and testbench

- Round-robin arbiter that produces the registered one-hot select for the team's one-hot data mux CBB.
- N requesters compete; the winner's grant is held stable until the downstream consumer completes a transfer.
- Optional lock keeps the grant for multi-beat transfers.
- Sits directly upstream of the mux: grant_o drives the mux sel, and the mux output feeds the consumer that returns ready_i.

---
 rtl/cbb_pkg.sv | 14 +
 rtl/cbb_rr_pick.sv | 36 +++
 rtl/cbb_rr_arb.sv | 105 ++++++++++
 tb/tb_cbb_rr_arb.sv | 196 +++++++++++++++++++
 4 files changed

// File: rtl/cbb_pkg.sv
// Shared definitions for the round-robin arbiter CBB: FSM encoding and index width helper.
package cbb_pkg;

   typedef enum logic {
      IDLE  = 1'b0,
      GRANT = 1'b1
   } arb_state_e;

   // Index width that never collapses to zero for a single requester.
   function automatic int cbb_clog2(input int n);
      return (n <= 1) ? 1 : $clog2(n);
   endfunction

endpackage

// File: rtl/cbb_rr_pick.sv
// Combinational round-robin pick: first set request at or after ptr, wrapping modulo N.
module cbb_rr_pick
   import cbb_pkg::*;
#(
   parameter int N    = 4,
   parameter int IDXW = cbb_clog2(N)
) (
   input  logic [N-1:0]    req,
   input  logic [IDXW-1:0] ptr,
   output logic            any,
   output logic [IDXW-1:0] win_idx,
   output logic [N-1:0]    win_oh
);

   int w_j;

   // NOTE: every output gets a default before the loop so no path leaves a value held, which would infer a latch.
   always_comb begin
      any     = 1'b0;
      win_idx = '0;
      win_oh  = '0;
      w_j     = 0;
      // Walk offsets from farthest to nearest so the closest request to ptr is written last and wins.
      // NOTE: blocking assignments here on purpose; later loop iterations must see and override earlier ones.
      for (int k = N - 1; k >= 0; k--) begin
         w_j = (int'(ptr) + k) % N;
         if (req[w_j]) begin
            any         = 1'b1;
            win_idx     = IDXW'(w_j);
            win_oh      = '0;
            win_oh[w_j] = 1'b1;
         end
      end
   end

endmodule

// File: rtl/cbb_rr_arb.sv
// Round-robin arbiter with held grant, optional lock and back-to-back re-arbitration; drives one-hot mux sel.
module cbb_rr_arb
   import cbb_pkg::*;
#(
   parameter int N    = 4,
   parameter int IDXW = cbb_clog2(N)
) (
   input  logic            clk,
   input  logic            rst_n,
   input  logic [N-1:0]    req_i,
   input  logic            lock_i,
   input  logic            ready_i,
   output logic [N-1:0]    grant_o,
   output logic [IDXW-1:0] grant_idx_o,
   output logic            grant_vld_o
);

   arb_state_e      r_state, w_nxt_state;
   logic [IDXW-1:0] r_ptr, w_nxt_ptr;
   logic [N-1:0]    r_grant, w_nxt_grant;
   logic [IDXW-1:0] r_idx, w_nxt_idx;
   logic            r_vld, w_nxt_vld;

   logic            w_xfer;
   logic [IDXW-1:0] w_ptr_inc;
   logic [IDXW-1:0] w_pick_ptr;
   logic            w_any;
   logic [IDXW-1:0] w_win_idx;
   logic [N-1:0]    w_win_oh;

   assign w_xfer     = r_vld & ready_i;
   assign w_ptr_inc  = (r_idx == IDXW'(N - 1)) ? '0 : r_idx + IDXW'(1);
   // In GRANT the pick is only consumed on an unlocked transfer, where the advanced ptr applies.
   assign w_pick_ptr = (r_state == GRANT) ? w_ptr_inc : r_ptr;

   cbb_rr_pick #(.N(N), .IDXW(IDXW)) u_pick (
      .req     (req_i),
      .ptr     (w_pick_ptr),
      .any     (w_any),
      .win_idx (w_win_idx),
      .win_oh  (w_win_oh)
   );

   always_comb begin
      w_nxt_state = r_state;
      w_nxt_ptr   = r_ptr;
      w_nxt_grant = r_grant;
      w_nxt_idx   = r_idx;
      w_nxt_vld   = r_vld;
      case (r_state)
         IDLE: begin
            if (w_any) begin
               w_nxt_state = GRANT;
               w_nxt_grant = w_win_oh;
               w_nxt_idx   = w_win_idx;
               w_nxt_vld   = 1'b1;
            end
         end
         GRANT: begin
            if (w_xfer) begin
               if (!lock_i) begin
                  w_nxt_ptr = w_ptr_inc;
                  if (w_any) begin
                     w_nxt_grant = w_win_oh;
                     w_nxt_idx   = w_win_idx;
                  end else begin
                     w_nxt_state = IDLE;
                     w_nxt_grant = '0;
                     w_nxt_idx   = '0;
                     w_nxt_vld   = 1'b0;
                  end
               end
            end else if (!req_i[r_idx]) begin
               w_nxt_state = IDLE;
               w_nxt_grant = '0;
               w_nxt_idx   = '0;
               w_nxt_vld   = 1'b0;
            end
         end
         default: w_nxt_state = IDLE;
      endcase
   end

   // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_state <= IDLE;
         r_ptr   <= '0;
         r_grant <= '0;
         r_idx   <= '0;
         r_vld   <= 1'b0;
      end else begin
         r_state <= w_nxt_state;
         r_ptr   <= w_nxt_ptr;
         r_grant <= w_nxt_grant;
         r_idx   <= w_nxt_idx;
         r_vld   <= w_nxt_vld;
      end
   end

   assign grant_o     = r_grant;
   assign grant_idx_o = r_idx;
   assign grant_vld_o = r_vld;

endmodule

// File: tb/tb_cbb_rr_arb.sv
// Directed bench for cbb_rr_arb: integer-level arbitration model checked every cycle plus literal expectations.
module tb_cbb_rr_arb;
   import cbb_pkg::*;

   localparam int N    = 4;
   localparam int IDXW = cbb_clog2(N);

   logic            clk = 1'b0;
   logic            rst_n;
   logic [N-1:0]    req_i;
   logic            lock_i;
   logic            ready_i;
   logic [N-1:0]    grant_o;
   logic [IDXW-1:0] grant_idx_o;
   logic            grant_vld_o;

   int total = 0;
   int bad   = 0;

   // Model: whether a grant is held, who holds it, and where the next search starts.
   bit m_vld;
   int m_idx;
   int m_ptr;

   cbb_rr_arb #(.N(N)) dut (
      .clk         (clk),
      .rst_n       (rst_n),
      .req_i       (req_i),
      .lock_i      (lock_i),
      .ready_i     (ready_i),
      .grant_o     (grant_o),
      .grant_idx_o (grant_idx_o),
      .grant_vld_o (grant_vld_o)
   );

   always #5 clk = ~clk;

   task automatic check(input string name, input int unsigned act, input int unsigned exp);
      total++;
      if (act !== exp) begin
         bad++;
         $display("FAIL %s: got %0h expected %0h", name, act, exp);
      end
   endtask

   function automatic int rr_pick(input logic [N-1:0] req, input int ptr);
      for (int k = 0; k < N; k++)
         if (req[(ptr + k) % N]) return (ptr + k) % N;
      return -1;
   endfunction

   always @(posedge clk or negedge rst_n) begin
      int w;
      if (!rst_n) begin
         m_vld = 0;
         m_idx = 0;
         m_ptr = 0;
      end else if (m_vld) begin
         if (ready_i) begin
            if (!lock_i) begin
               m_ptr = (m_idx + 1) % N;
               w = rr_pick(req_i, m_ptr);
               if (w >= 0) m_idx = w;
               else m_vld = 0;
            end
         end else if (!req_i[m_idx]) begin
            m_vld = 0;
         end
      end else begin
         w = rr_pick(req_i, m_ptr);
         if (w >= 0) begin
            m_vld = 1;
            m_idx = w;
         end
      end
   end

   always @(negedge clk) begin
      check("model_grant", grant_o, m_vld ? (1 << m_idx) : 0);
      check("model_vld", grant_vld_o, m_vld);
      if (m_vld) check("model_idx", grant_idx_o, m_idx);
   end

   task automatic tick();
      @(negedge clk);
      #1;
   endtask

   task automatic drive(input logic [N-1:0] req, input logic lock, input logic ready);
      req_i   = req;
      lock_i  = lock;
      ready_i = ready;
   endtask

   initial begin
      #100000;
      $display("FAIL watchdog: got timeout expected finish");
      $fatal(1, "watchdog expired");
   end

   initial begin
      rst_n = 1'b0;
      drive(4'b1111, 1'b0, 1'b0);

      // 1: reset, then first grant from ptr=0
      tick(); tick();
      check("rst_grant", grant_o, 4'b0000);
      check("rst_vld", grant_vld_o, 1'b0);
      check("rst_idx", grant_idx_o, 0);
      rst_n = 1'b1;
      tick();
      check("first_grant", grant_o, 4'b0001);
      check("first_idx", grant_idx_o, 0);

      // 2: full rotation without gaps
      drive(4'b1111, 1'b0, 1'b1);
      for (int i = 1; i <= 4; i++) begin
         tick();
         check("rot_idx", grant_idx_o, i % 4);
         check("rot_vld", grant_vld_o, 1'b1);
      end

      // 3: hold under backpressure, then wrap search from ptr=3
      drive(4'b0100, 1'b0, 1'b1);
      tick();
      check("bp_load", grant_o, 4'b0100);
      for (int i = 0; i < 5; i++) begin
         drive(4'b0100 | ((i % 2) ? 4'b0001 : 4'b0010), 1'b0, 1'b0);
         tick();
         check("bp_hold", grant_o, 4'b0100);
      end
      drive(4'b0011, 1'b0, 1'b1);
      tick();
      check("bp_wrap", grant_o, 4'b0001);

      // 4: lock holds idx 1 across three locked transfers
      drive(4'b0010, 1'b0, 1'b1);
      tick();
      check("lock_load", grant_o, 4'b0010);
      drive(4'b1111, 1'b1, 1'b1);
      for (int i = 0; i < 3; i++) begin
         tick();
         check("lock_hold", grant_o, 4'b0010);
      end
      drive(4'b1111, 1'b0, 1'b1);
      tick();
      check("lock_release", grant_o, 4'b0100);

      // 5: withdraw leaves ptr at its pre-grant value
      drive(4'b1000, 1'b0, 1'b1);
      tick();
      check("wd_load", grant_o, 4'b1000);
      drive(4'b0000, 1'b0, 1'b0);
      tick();
      check("wd_vld", grant_vld_o, 1'b0);
      check("wd_grant", grant_o, 4'b0000);
      drive(4'b0000, 1'b0, 1'b1);
      tick();
      check("idle_ready", grant_vld_o, 1'b0);
      drive(4'b1001, 1'b0, 1'b0);
      tick();
      check("wd_rereq", grant_o, 4'b1000);
      drive(4'b0000, 1'b0, 1'b0);
      tick();
      drive(4'b0001, 1'b0, 1'b0);
      tick();
      check("wd_other", grant_o, 4'b0001);
      // transfer and withdraw together: ptr advances to 1
      drive(4'b0110, 1'b0, 1'b1);
      tick();
      check("xfer_wd", grant_o, 4'b0010);

      // 6: async reset mid-lock clears outputs before any edge
      drive(4'b0100, 1'b0, 1'b1);
      tick();
      check("arst_load", grant_o, 4'b0100);
      drive(4'b1111, 1'b1, 1'b1);
      tick();
      check("arst_locked", grant_o, 4'b0100);
      #1 rst_n = 1'b0;
      #1;
      check("arst_grant", grant_o, 4'b0000);
      check("arst_vld", grant_vld_o, 1'b0);
      check("arst_idx", grant_idx_o, 0);
      tick();
      rst_n = 1'b1;
      drive(4'b1010, 1'b0, 1'b0);
      tick();
      check("arst_restart", grant_o, 4'b0010);

      tick();
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
